// File: rtl/fp_norm_round.sv
// Two-stage normalize (S1) and round-to-24-bit (S2) pipeline feeding the single-precision pack stage.
// Define FP_ROUND_MODE_EN to add the rm_i rounding-mode input; otherwise only round-to-nearest-even is used.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [FRAC_W+4:0] sig_raw_i,
    input  logic              nan_i,
`ifdef FP_ROUND_MODE_EN
    input  logic [2:0]        rm_i,
`endif
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [FRAC_W+3:0] sig_untrunc_o,
    output logic              carry_o,
    output logic              nan_o
);

    localparam int RAW_W = FRAC_W + 5;
    localparam int SIG_W = FRAC_W + 4;
    localparam int MAN_W = FRAC_W + 1;
    localparam int EW    = EXP_W + 1;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic              s2_ready;

    logic              s1_valid;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [SIG_W-1:0]  s1_sig;
    logic              s1_carry;
    logic              s1_nan;
`ifdef FP_ROUND_MODE_EN
    logic [2:0]        s1_rm;
`endif

    logic [EW-1:0]     lzc;
    logic [EW-1:0]     exp_m1;
    logic [EW-1:0]     shamt;
    logic [SIG_W-1:0]  sig_shl;
    logic [SIG_W-1:0]  sig_n;
    logic [EW-1:0]     exp_n;
    logic              s1_ovf;
    logic [EXP_W-1:0]  exp_s1;

    logic [2:0]        grs;
    logic              lsb;
    logic              round_up;
    logic [MAN_W:0]    man_sum;
    logic [MAN_W-1:0]  man_r;
    logic [EW-1:0]     exp_r;
    logic              s2_ovf;
    logic [EXP_W-1:0]  exp_s2;

    assign s2_ready   = ~out_valid_o | out_ready_i;
    assign in_ready_o = ~s1_valid | s2_ready;

    // Leading-zero count of the 27-bit significand; the highest set bit wins.
    always_comb begin
        lzc = EW'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (sig_raw_i[i]) begin
                lzc = EW'(SIG_W - 1 - i);
            end
        end
    end

    always_comb begin
        exp_m1  = {1'b0, exp_i} - EW'(1);
        shamt   = (lzc < exp_m1) ? lzc : exp_m1;
        sig_shl = sig_raw_i[SIG_W-1:0] << shamt;
        sig_n   = sig_raw_i[SIG_W-1:0];
        exp_n   = {1'b0, exp_i};
        if (sig_raw_i[RAW_W-1]) begin
            sig_n = {sig_raw_i[RAW_W-1:2], sig_raw_i[1] | sig_raw_i[0]};
            exp_n = {1'b0, exp_i} + EW'(1);
        end else if (sig_raw_i == '0) begin
            sig_n = '0;
            exp_n = '0;
        end else if (exp_i != '0) begin
            // Left shift is capped so the exponent never drops below 1; an
            // unnormalized result after the cap is a denormal (exp field 0).
            sig_n = sig_shl;
            exp_n = {1'b0, exp_i} - shamt;
            if (!sig_shl[SIG_W-1]) begin
                exp_n = '0;
            end
        end
        s1_ovf = (exp_n >= EXP_MAX);
        exp_s1 = s1_ovf ? EXP_MAX[EXP_W-1:0] : exp_n[EXP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_sig   <= '0;
            s1_carry <= 1'b0;
            s1_nan   <= 1'b0;
`ifdef FP_ROUND_MODE_EN
            s1_rm    <= 3'd0;
`endif
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sign  <= sign_i;
                s1_exp   <= exp_s1;
                s1_sig   <= sig_n;
                s1_carry <= s1_ovf;
                s1_nan   <= nan_i;
`ifdef FP_ROUND_MODE_EN
                s1_rm    <= rm_i;
`endif
            end
        end
    end

    always_comb begin
        grs = s1_sig[2:0];
        lsb = s1_sig[3];
`ifdef FP_ROUND_MODE_EN
        case (s1_rm)
            3'd1:    round_up = 1'b0;
            3'd2:    round_up = s1_sign & (|grs);
            3'd3:    round_up = ~s1_sign & (|grs);
            3'd4:    round_up = grs[2];
            default: round_up = grs[2] & (lsb | grs[1] | grs[0]);
        endcase
`else
        round_up = grs[2] & (lsb | grs[1] | grs[0]);
`endif
        man_sum = {1'b0, s1_sig[SIG_W-1:3]} + {{MAN_W{1'b0}}, round_up};
        exp_r   = {1'b0, s1_exp};
        if (man_sum[MAN_W]) begin
            man_r = man_sum[MAN_W:1];
            exp_r = {1'b0, s1_exp} + EW'(1);
        end else begin
            man_r = man_sum[MAN_W-1:0];
            // A denormal that rounds up into the hidden bit becomes the smallest normal.
            if (s1_exp == '0 && man_sum[MAN_W-1] && !s1_sig[SIG_W-1]) begin
                exp_r = EW'(1);
            end
        end
        s2_ovf = (exp_r >= EXP_MAX);
        exp_s2 = s2_ovf ? EXP_MAX[EXP_W-1:0] : exp_r[EXP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o   <= 1'b0;
            sign_o        <= 1'b0;
            exp_o         <= '0;
            sig_untrunc_o <= '0;
            carry_o       <= 1'b0;
            nan_o         <= 1'b0;
        end else if (s2_ready) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                sign_o        <= s1_sign;
                exp_o         <= exp_s2;
                sig_untrunc_o <= {man_r, grs};
                carry_o       <= s1_carry | s2_ovf;
                nan_o         <= s1_nan;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors, backpressure/reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_fp_norm_round;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] raw;
        logic        nan;
        logic [2:0]  rm;
    } stim_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] sig;
        logic        carry;
        logic        nan;
    } out_t;

    typedef struct {
        string name;
        stim_t s;
        out_t  e;
    } vec_t;

    localparam longint P23 = 64'd8388608;
    localparam longint P24 = 64'd16777216;
    localparam longint P26 = 64'd67108864;
    localparam int     NVEC = 15;
    localparam int     NRAND = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic        carry_out;
    logic        nan_out;
    logic [7:0]  exp_out;
    logic [26:0] sig_untrunc;
    stim_t       cur = '0;
    out_t        act;
    out_t        prev_act;
    bit          prev_stall = 1'b0;
    bit          rand_bp = 1'b0;
    int          errors = 0;
    int          checks = 0;
    out_t        exp_q[$];
    out_t        seen[$];
    vec_t        vecs[NVEC];

    fp_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .sign_i       (cur.sign),
        .exp_i        (cur.exp),
        .sig_raw_i    (cur.raw),
        .nan_i        (cur.nan),
`ifdef FP_ROUND_MODE_EN
        .rm_i         (cur.rm),
`endif
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .sign_o       (sign_out),
        .exp_o        (exp_out),
        .sig_untrunc_o(sig_untrunc),
        .carry_o      (carry_out),
        .nan_o        (nan_out)
    );

    assign act = {sign_out, exp_out, sig_untrunc, carry_out, nan_out};

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: normalize by repeated doubling, round on the integer significand.
    function automatic out_t refModel(input stim_t s);
        longint sig;
        longint mant;
        longint grs;
        int     e;
        bit     ovf;
        bit     up;
        out_t   r;
        ovf = 1'b0;
        sig = longint'(s.raw);
        e   = int'(s.exp);
        if (s.raw[27]) begin
            sig = (sig >> 1) | (sig & 1);
            e   = e + 1;
        end else if (sig == 0) begin
            e = 0;
        end else if (e != 0) begin
            while (sig < P26 && e > 1) begin
                sig = sig * 2;
                e   = e - 1;
            end
            if (sig < P26) e = 0;
        end
        if (e >= 255) begin ovf = 1'b1; e = 255; end
        mant = sig / 8;
        grs  = sig % 8;
        case (s.rm)
            3'd1:    up = 1'b0;
            3'd2:    up = s.sign && grs != 0;
            3'd3:    up = !s.sign && grs != 0;
            3'd4:    up = grs >= 4;
            default: up = grs > 4 || (grs == 4 && (mant % 2) == 1);
        endcase
        if (up) begin
            if (mant + 1 >= P24) begin
                mant = (mant + 1) / 2;
                e    = e + 1;
            end else begin
                if (e == 0 && mant + 1 >= P23 && mant < P23) e = 1;
                mant = mant + 1;
            end
        end
        if (e >= 255) begin ovf = 1'b1; e = 255; end
        r.sign  = s.sign;
        r.exp   = 8'(e);
        r.sig   = 27'(mant * 8 + grs);
        r.carry = ovf;
        r.nan   = s.nan;
        return r;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        int    sel;
        s.sign = 1'($urandom);
        s.nan  = ($urandom_range(0, 15) == 0);
        sel    = int'($urandom_range(0, 3));
        if (sel == 0)      s.exp = 8'($urandom_range(0, 3));
        else if (sel == 1) s.exp = 8'($urandom_range(250, 255));
        else               s.exp = 8'($urandom_range(0, 255));
        s.raw = 28'($urandom) >> $urandom_range(0, 27);
        if ($urandom_range(0, 3) == 0) s.raw[2:0] = 3'b100;
        if ($urandom_range(0, 15) == 0) s.raw = '0;
`ifdef FP_ROUND_MODE_EN
        s.rm = 3'($urandom_range(0, 7));
`else
        s.rm = 3'd0;
`endif
        return s;
    endfunction

    function automatic vec_t mkVec(input string n, input logic sg, input logic [7:0] ex,
                                   input logic [27:0] rw, input logic nn, input logic [7:0] eexp,
                                   input logic [26:0] esig, input logic ecarry);
        vec_t v;
        v.name = n;
        v.s    = {sg, ex, rw, nn, 3'd0};
        v.e    = {sg, eexp, esig, ecarry, nn};
        return v;
    endfunction

    task automatic compareOut(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic applyStimulus(input stim_t s);
        int n;
        cur      = s;
        in_valid = 1'b1;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got no accept, expected in_ready within 60 cycles");
                break;
            end
            tick();
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input out_t want, input int want_lat);
        int   n;
        out_t got;
        n = 0;
        while (seen.size() == 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (seen.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no output, expected %h", name, want);
            return;
        end
        got = seen.pop_front();
        compareOut(name, got, want);
        if (want_lat >= 0) begin
            checks++;
            if (n != want_lat) begin
                errors++;
                $display("[TB] FAIL %s_latency: got %0d expected %0d", name, n, want_lat);
            end
        end
    endtask

    initial begin
        out_t mon_want;

        vecs[0]  = mkVec("one_plus_one",    0, 8'd127, 28'h8000000, 0, 8'd128, 27'h4000000, 0);
        vecs[1]  = mkVec("tie_round_up",    0, 8'd127, 28'h400000C, 0, 8'd127, 27'h4000014, 0);
        vecs[2]  = mkVec("tie_even",        0, 8'd127, 28'h4000004, 0, 8'd127, 27'h4000004, 0);
        vecs[3]  = mkVec("left_norm",       0, 8'd10,  28'h0800000, 0, 8'd7,   27'h4000000, 0);
        vecs[4]  = mkVec("denorm_clamp",    0, 8'd2,   28'h0800000, 0, 8'd0,   27'h1000000, 0);
        vecs[5]  = mkVec("overflow_s1",     0, 8'd254, 28'h8000000, 0, 8'hFF,  27'h4000000, 1);
        vecs[6]  = mkVec("overflow_round",  0, 8'd254, 28'h7FFFFFC, 0, 8'hFF,  27'h4000004, 1);
        vecs[7]  = mkVec("zero",            0, 8'd100, 28'h0000000, 0, 8'd0,   27'h0000000, 0);
        vecs[8]  = mkVec("denorm_to_norm",  0, 8'd0,   28'h3FFFFFC, 0, 8'd1,   27'h4000004, 0);
        vecs[9]  = mkVec("carry_sticky",    0, 8'd127, 28'h8000001, 0, 8'd128, 27'h4000001, 0);
        vecs[10] = mkVec("round_g_r",       1, 8'd50,  28'h4000006, 0, 8'd50,  27'h400000E, 0);
        vecs[11] = mkVec("nan_pass",        1, 8'd127, 28'h8000000, 1, 8'd128, 27'h4000000, 0);
        vecs[12] = mkVec("round_carry_27",  0, 8'd100, 28'h7FFFFFF, 0, 8'd101, 27'h4000007, 0);
        vecs[13] = mkVec("denorm_keep",     0, 8'd0,   28'h0000010, 0, 8'd0,   27'h0000010, 0);
        vecs[14] = mkVec("deep_left_norm",  0, 8'd127, 28'h0000001, 0, 8'd101, 27'h4000000, 0);

        // Scoreboard monitor: predicts on accept, scores on emit, and checks stall stability.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        checkBit("hold_valid", out_valid, 1'b1);
                        compareOut("hold_data", act, prev_act);
                    end
                    if (in_valid && in_ready) exp_q.push_back(refModel(cur));
                    if (out_valid && out_ready) begin
                        seen.push_back(act);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_output: got %h expected none", act);
                        end else begin
                            mon_want = exp_q.pop_front();
                            compareOut("model", act, mon_want);
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_act   = act;
                end
            end
        join_none

        @(negedge clk);
        checkBit("reset_out_valid", out_valid, 1'b0);
        compareOut("reset_outputs", act, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("ready_after_reset", in_ready, 1'b1);
        tick();
        out_ready = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput(vecs[i].name, vecs[i].e, 2);
            tick();
        end

        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        applyStimulus(vecs[0].s);
        applyStimulus(vecs[1].s);
        cur      = vecs[3].s;
        in_valid = 1'b1;
        @(negedge clk);
        checkBit("bp_in_ready_low", in_ready, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (seen.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_no_emit: got %0d outputs expected 0", seen.size());
        end
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (in_ready) break;
            tick();
        end
        tick();
        in_valid = 1'b0;
        checkOutput("bp_first", vecs[0].e, -1);
        checkOutput("bp_second", vecs[1].e, -1);
        checkOutput("bp_third", vecs[3].e, -1);
        repeat (4) tick();
        checks++;
        if (seen.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_no_dup: got %0d extra outputs expected 0", seen.size());
        end

        $display("[TB] mid-stream reset sequence");
        applyStimulus(vecs[5].s);
        applyStimulus(vecs[6].s);
        #1;
        rst_n = 1'b0;
        #1;
        checkBit("reset_drops_valid", out_valid, 1'b0);
        checkBit("reset_ready", in_ready, 1'b1);
        exp_q.delete();
        seen.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (seen.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_stale: got %0d outputs valid=%b expected 0 outputs valid=0", seen.size(), out_valid);
        end
        applyStimulus(vecs[12].s);
        checkOutput("after_reset", vecs[12].e, 2);
        tick();

        $display("[TB] random traffic");
        rand_bp = 1'b1;
        for (int i = 0; i < NRAND; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(randStim());
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        seen.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
Pipelined normalize-and-round stage for the single-precision add/sub datapath. It sits directly upstream of the error-check/pack stage. It takes the raw aligned sum (with adder carry-out and G/R/S bits), normalizes it, and rounds it to 24 significant bits. It presents exactly the sign/exp/sig_untrunc/carry/nan bundle the pack stage consumes. It is a 2-stage valid/ready pipeline: S1 normalize, S2 round.

Parameters:
EXP_W, 8, exponent width; all-ones means overflow/inf
FRAC_W, 23, stored fraction width; sig_raw is FRAC_W+5 bits, sig_untrunc is FRAC_W+4 bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid_i  in  1  input bundle valid
in_ready_o  out  1  stage can accept input
sign_i  in  1  result sign
exp_i  in  EXP_W  biased exponent of the unnormalized sum
sig_raw_i  in  28  [27]=adder carry-out, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=S
nan_i  in  1  NaN operand or invalid op detected upstream
out_valid_o  out  1  output bundle valid
out_ready_i  in  1  downstream accepts
sign_o  out  1  sign, passed through
exp_o  out  EXP_W  final biased exponent
sig_untrunc_o  out  27  [26:3]=rounded significand incl. hidden bit, [2:0]=pre-round GRS (nonzero means inexact)
carry_o  out  1  exponent overflow (exp reached all-ones)
nan_o  out  1  nan_i, passed through

Behaviour:
- Reset (async, rst_n=0): both stage valid flags cleared; all output data registers 0; out_valid_o=0. in_ready_o=1 once reset is released. Reset mid-operation discards in-flight data.
- Handshake: transfer when valid&ready. s2_ready = ~s2_valid | out_ready_i. in_ready_o = ~s1_valid | s2_ready, purely combinational, with no bubbles at full throughput.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Latency: 2 cycles from input accept to out_valid_o, given no backpressure. Throughput 1/cycle. Order preserved.
- S1 normalize:
  - If sig_raw[27]=1: shift right 1, fold the shifted-out bit into S, exp+1.
  - Else if sig_raw=0: exp=0, sig=0, no shift.
  - Else if exp_i=0: no shift (already denormal).
  - Else: lzc = leading zeros of sig_raw[26:0]; s = min(lzc, exp_i-1). Shift left by s, exp = exp_i - s. If bit26 is still 0 afterwards, exp=0 (denormal result).
  - Bits shifted right always OR into sticky.
- S2 round, RNE:
  - L=sig[3], G=sig[2], R|S=sticky. round_up = G & (L|R|S). Add 1 to sig[26:3].
  - Increment carries into bit 27: shift right 1, exp+1.
  - exp=0 and rounding sets bit26: exp becomes 1.
  - sig_untrunc_o[2:0] = pre-round GRS.
- Overflow: if exp reaches 2^EXP_W-1 in S1 or S2, carry_o=1 and exp_o saturates at all-ones.
- nan_i=1: datapath computed normally and ignored downstream. nan_o=1, carry_o computed as normal.
- Exponent arithmetic uses EXP_W+1 bits internally; no wrap-around.

Optional Feature:
FP_ROUND_MODE_EN:
- Defined: adds input rm_i[2:0] (RISC-V encoding), sampled with the data and piped with it.
- Modes:
  - 0 RNE
  - 1 RTZ (never round up)
  - 2 RDN (round up iff sign=1 & GRS!=0)
  - 3 RUP (round up iff sign=0 & GRS!=0)
  - 4 RMM (round up iff G)
  - 5-7 treated as RNE.
- Undefined: no rm_i port, RNE only.

Test Plan:
- 1.0+1.0: exp_i=127, sig_raw=28'h8000000 -> after 2 cycles exp_o=128, sig_untrunc_o=27'h4000000, carry_o=0.
- Tie round-up to even: exp_i=127, sig_raw=28'h400000C -> sig_untrunc_o=27'h4000014, exp_o=127.
- Tie stays even: sig_raw=28'h4000004 -> sig_untrunc_o=27'h4000004.
- Left normalize: exp_i=10, sig_raw=28'h0800000 -> exp_o=7, sig_untrunc_o=27'h4000000.
- Denormal clamp: exp_i=2, sig_raw=28'h0800000 -> exp_o=0, sig_untrunc_o=27'h1000000.
- Overflow: exp_i=254, sig_raw=28'h8000000 -> carry_o=1, exp_o=8'hFF.
- Backpressure: hold out_ready_i=0 and send 3 back-to-back inputs -> in_ready_o=0 after 2 accepts. Release -> all 3 emerge in order with no loss or duplication.
- Mid-stream rst_n pulse -> out_valid_o=0 immediately; no stale data afterwards.
